// File: rtl/ibuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_pkg
//  Description : Shared definitions for the Rx input-buffer (ibuf) writer
//                (mac2ibuf) and its drain stage (ibuf2axis). Fixes the RAM
//                word layout {tdat[63:0], tkep[7:1], tlst} and the drain FSM
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ibuf_pkg;

    localparam int IBUF_DW  = 72;   // ibuf word width
    localparam int IBUF_AW  = 10;   // default ibuf address width

    // Field positions inside one ibuf word
    localparam int TLST_BIT = 0;
    localparam int TKEP_LSB = 1;
    localparam int TKEP_W   = 7;    // keep[0] is implied, only keep[7:1] stored
    localparam int TDAT_LSB = 8;
    localparam int TDAT_W   = 64;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } drain_state_e;

    // Rebuild the 8-bit AXIS keep from the low byte of an ibuf word. Byte 0
    // of every beat is always valid, so its keep bit is not stored.
    function automatic logic [7:0] word_tkep(input logic [7:0] lo_byte);
        return {lo_byte[TKEP_LSB +: TKEP_W], 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibuf2axis_q.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf2axis_q
//  Description : QD-deep first-word-fall-through register FIFO used as the
//                output holding queue of ibuf2axis. dout_o shows the head
//                word whenever empty_o is low and only changes on a pop.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   1            clock
//    rst      in   1            synchronous active-high reset, empties FIFO
//    push_i   in   1            write din_i this clk
//    din_i    in   DW           write data
//    pop_i    in   1            consume head word this clk (ignored if empty)
//    dout_o   out  DW           head word
//    empty_o  out  1            FIFO holds no word
//    count_o  out  clog2(QD+1)  number of words held
// ============================================================================
module ibuf2axis_q #(
    parameter int QD = 4,
    parameter int DW = 72
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            din_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            dout_o,
    output logic                     empty_o,
    output logic [$clog2(QD+1)-1:0]  count_o
);

    localparam int CW = $clog2(QD + 1);
    localparam int IW = (QD > 1) ? $clog2(QD) : 1;

    logic [DW-1:0] mem_q [QD];
    logic [IW-1:0] wr_idx_q;
    logic [IW-1:0] rd_idx_q;
    logic [CW-1:0] count_q;

    logic          full;
    logic          do_push;
    logic          do_pop;

    // Index increment that also works for non-power-of-two depths
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(QD - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign full    = (count_q == CW'(QD));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same clk frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_idx_q <= next_idx(wr_idx_q);
            end
            if (do_pop) begin
                rd_idx_q <= next_idx(rd_idx_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_idx_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ibuf2axis.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf2axis
//  Description : Drain stage of the Rx input buffer. Reads frames that the
//                writer has committed (committed_prod_i) out of the ibuf RAM
//                and replays them as a 64-bit AXI-Stream with backpressure.
//                After the last beat of a frame is accepted the consumer
//                pointer committed_cons_o is advanced to release the space.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk               in   1     clock
//    rst               in   1     synchronous active-high reset
//    rd_addr_o         out  AW    ibuf read address
//    rd_en_o           out  1     ibuf read enable (data returns 1 clk later)
//    rd_data_i         in   DW    ibuf read data
//    committed_prod_i  in   AW+1  producer pointer from the writer
//    committed_cons_o  out  AW+1  consumer pointer back to the writer
//    tdat_o            out  64    AXIS data
//    tkep_o            out  8     AXIS keep
//    tval_o            out  1     AXIS valid
//    tlst_o            out  1     AXIS last
//    trdy_i            in   1     AXIS ready
//    fwd_pkts_o        out  16    frames fully sent, wraps at 2^16
// ============================================================================
module ibuf2axis
    import ibuf_pkg::*;
#(
    parameter int AW = IBUF_AW,
    parameter int DW = IBUF_DW,
    parameter int QD = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_en_o,
    input  logic [DW-1:0] rd_data_i,
    input  logic [AW:0]   committed_prod_i,
    output logic [AW:0]   committed_cons_o,
    output logic [63:0]   tdat_o,
    output logic [7:0]    tkep_o,
    output logic          tval_o,
    output logic          tlst_o,
    input  logic          trdy_i,
    output logic [15:0]   fwd_pkts_o
);

    localparam int CW = $clog2(QD + 1);
    localparam int OW = CW + 1;

    drain_state_e  state_q, state_d;

    logic [AW:0]   rd_ptr_q,  rd_ptr_d;
    logic          rd_en_q,   rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    // Read issued last clk: its word is on rd_data_i now and is pushed at
    // the coming edge.
    logic          inflight_q;
    logic [AW:0]   out_ptr_q;
    logic [AW:0]   cons_q;
    logic [15:0]   pkts_q;

    logic [DW-1:0] q_dout;
    logic          q_empty;
    logic [CW-1:0] q_count;

    logic          pop;
    logic          has_room;
    logic [OW-1:0] occupancy;
    logic [OW-1:0] limit;

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    ibuf2axis_q #(
        .QD (QD),
        .DW (DW)
    ) u_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (rd_data_i),
        .pop_i   (pop),
        .dout_o  (q_dout),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // tval depends only on queue state, so trdy never reaches tval
    // combinationally.
    assign pop = !q_empty && trdy_i;

    // Every word already in the queue or still travelling from the RAM
    // owns a slot. A pop this clk frees one, which is what lets the
    // pipeline sustain 1 beat/clk with a shallow queue.
    assign occupancy = OW'(q_count) + OW'(rd_en_q) + OW'(inflight_q);
    assign limit     = OW'(QD) + OW'(pop);
    assign has_room  = (occupancy < limit);

    // ------------------------------------------------------------------
    // FSM and read issue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_ptr_d  = rd_ptr_q;
        case (state_q)
            ST_INIT: begin
                rd_ptr_d = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                // The full AW+1 compare keeps a completely full buffer
                // distinct from an empty one.
                if ((rd_ptr_q != committed_prod_i) && has_room) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_ptr_q[AW-1:0];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            out_ptr_q  <= '0;
            cons_q     <= '0;
            pkts_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= rd_en_q;
            if (pop) begin
                out_ptr_q <= out_ptr_q + 1'b1;
                // Space goes back to the writer only on frame boundaries
                if (q_dout[TLST_BIT]) begin
                    cons_q <= out_ptr_q + 1'b1;
                    pkts_q <= pkts_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_en_o          = rd_en_q;
    assign rd_addr_o        = rd_addr_q;
    assign committed_cons_o = cons_q;
    assign fwd_pkts_o       = pkts_q;

    assign tval_o = !q_empty;
    assign tdat_o = q_dout[TDAT_LSB +: TDAT_W];
    assign tkep_o = word_tkep(q_dout[7:0]);
    assign tlst_o = q_dout[TLST_BIT];

endmodule
`default_nettype wire

// File: tb/tb_ibuf2axis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibuf2axis
//  Description : Self-checking bench for ibuf2axis with a behavioural
//                1-clk-latency ibuf RAM and a writer model. AW=8 so that
//                190-word frames fit and the wrap at 255->0 is reachable.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ibuf2axis;
    import ibuf_pkg::*;

    localparam int AW = 8;
    localparam int PW = AW + 1;
    localparam int QD = 4;
    localparam int DW = IBUF_DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic [PW-1:0] prod = '0;
    logic [PW-1:0] cons;
    logic [63:0]   tdat;
    logic [7:0]    tkep;
    logic          tval;
    logic          tlst;
    logic          trdy = 1'b0;
    logic [15:0]   pkts;

    logic [DW-1:0] mem [2**AW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ibuf RAM: data appears 1 clk after rd_en/rd_addr
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    ibuf2axis #(
        .AW (AW),
        .DW (DW),
        .QD (QD)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .rd_addr_o        (rd_addr),
        .rd_en_o          (rd_en),
        .rd_data_i        (rd_data),
        .committed_prod_i (prod),
        .committed_cons_o (cons),
        .tdat_o           (tdat),
        .tkep_o           (tkep),
        .tval_o           (tval),
        .tlst_o           (tlst),
        .trdy_i           (trdy),
        .fwd_pkts_o       (pkts)
    );

    function automatic logic [DW-1:0] mkw(input logic [63:0] d, input logic [7:0] k, input logic l);
        return {d, k[7:1], l};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst  = 1'b1;
        prod = '0;
        trdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_en, rd_addr} !== 9'd0) begin
            errors++; $display("FAIL reset_rd got en=%0b addr=%0d exp en=0 addr=0", rd_en, rd_addr);
        end
        checks++;
        if (cons !== 9'd0) begin
            errors++; $display("FAIL reset_cons got %0d exp 0", cons);
        end
        checks++;
        if (tval !== 1'b0) begin
            errors++; $display("FAIL reset_tval got %0b exp 0", tval);
        end
        checks++;
        if (pkts !== 16'd0) begin
            errors++; $display("FAIL reset_pkts got %0d exp 0", pkts);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_frame();
        logic [63:0] ed [3] = '{64'hA000_0000_0000_000A, 64'hB000_0000_0000_000B, 64'hC000_0000_0000_000C};
        logic [7:0]  ek [3] = '{8'hFF, 8'hFF, 8'h0F};
        logic        el [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) mem[i] = mkw(ed[i], ek[i], el[i]);
        trdy = 1'b1;
        prod = 9'd3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({rd_en, rd_addr} !== {1'b1, 8'd0}) begin
                    errors++; $display("FAIL t1_issue got en=%0b addr=%0d exp en=1 addr=0", rd_en, rd_addr);
                end
            end
            if (k < 3) begin
                checks++;
                if (tval !== 1'b0) begin
                    errors++; $display("FAIL t1_latency clk%0d tval got %0b exp 0", k, tval);
                end
            end else if (k <= 5) begin
                checks++;
                if ({tval, tdat, tkep, tlst} !== {1'b1, ed[k-3], ek[k-3], el[k-3]}) begin
                    errors++; $display("FAIL t1_beat%0d got v=%0b d=%h k=%h l=%0b exp v=1 d=%h k=%h l=%0b",
                                       k-3, tval, tdat, tkep, tlst, ed[k-3], ek[k-3], el[k-3]);
                end
            end
            if (k == 5) begin
                checks++;
                if (cons !== 9'd0) begin
                    errors++; $display("FAIL t1_cons_early got %0d exp 0", cons);
                end
            end
            if (k == 6) begin
                checks++;
                if ({tval, cons, pkts} !== {1'b0, 9'd3, 16'd1}) begin
                    errors++; $display("FAIL t1_done got tval=%0b cons=%0d pkts=%0d exp 0/3/1", tval, cons, pkts);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        logic [63:0] ed [3] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
        logic [7:0]  ek [3] = '{8'hFF, 8'hFF, 8'h0F};
        logic        el [3] = '{1'b0, 1'b0, 1'b1};
        bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit          ok = 1'b0;
        int          idx = 0;
        for (int i = 0; i < 3; i++) mem[3+i] = mkw(ed[i], ek[i], el[i]);
        trdy = 1'b0;
        prod = 9'd6;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            ok = tval;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL t2_timeout tval got 0 exp 1 within 10 clks");
        end
        for (int p = 0; p < 6; p++) begin
            trdy = pat[p];
            if (idx < 3) begin
                checks++;
                if ({tval, tdat, tkep, tlst} !== {1'b1, ed[idx], ek[idx], el[idx]}) begin
                    errors++; $display("FAIL t2_beat step%0d got v=%0b d=%h k=%h l=%0b exp v=1 d=%h k=%h l=%0b",
                                       p, tval, tdat, tkep, tlst, ed[idx], ek[idx], el[idx]);
                end
            end
            checks++;
            if (cons !== 9'd3) begin
                errors++; $display("FAIL t2_cons_mid step%0d got %0d exp 3", p, cons);
            end
            @(negedge clk);
            if (pat[p]) idx++;
        end
        checks++;
        if ({tval, cons, pkts} !== {1'b0, 9'd6, 16'd2}) begin
            errors++; $display("FAIL t2_done got tval=%0b cons=%0d pkts=%0d exp 0/6/2", tval, cons, pkts);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        logic [7:0]  ea [5] = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd2};
        logic [63:0] ed [5];
        logic [7:0]  ek [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
        logic        el [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          c;
        // Filler frame moves the pointers from 6 up to 254
        for (int i = 6; i <= 253; i++) mem[i] = mkw(64'(i), 8'hFF, i == 253);
        trdy = 1'b1;
        prod = 9'd254;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (cons !== 9'd254 && c < 400);
        checks++;
        if ({cons, pkts} !== {9'd254, 16'd3}) begin
            errors++; $display("FAIL t3_filler got cons=%0d pkts=%0d exp 254/3", cons, pkts);
        end
        for (int i = 0; i < 5; i++) begin
            ed[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
            mem[ea[i]] = mkw(ed[i], ek[i], el[i]);
        end
        prod = 9'd259;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                checks++;
                if ({rd_en, rd_addr} !== {1'b1, ea[k-1]}) begin
                    errors++; $display("FAIL t3_addr clk%0d got en=%0b addr=%0d exp en=1 addr=%0d",
                                       k, rd_en, rd_addr, ea[k-1]);
                end
            end
            if (k >= 3 && k <= 7) begin
                checks++;
                if ({tval, tdat, tkep, tlst} !== {1'b1, ed[k-3], ek[k-3], el[k-3]}) begin
                    errors++; $display("FAIL t3_beat%0d got v=%0b d=%h k=%h l=%0b exp v=1 d=%h k=%h l=%0b",
                                       k-3, tval, tdat, tkep, tlst, ed[k-3], ek[k-3], el[k-3]);
                end
            end
            if (k == 8) begin
                checks++;
                if ({tval, cons, pkts} !== {1'b0, 9'd259, 16'd4}) begin
                    errors++; $display("FAIL t3_done got tval=%0b cons=%0d pkts=%0d exp 0/259/4", tval, cons, pkts);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        // Eight 1-word frames at addresses 3..10, pointer values 259..266
        for (int i = 0; i < 8; i++) mem[3+i] = mkw(64'hB2B0 + 64'(i), 8'hFF, 1'b1);
        trdy = 1'b1;
        prod = 9'd260;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j <= 7) prod = 9'(260 + j);
            if (j >= 3 && j <= 10) begin
                checks++;
                if ({tval, tdat, tlst} !== {1'b1, 64'hB2B0 + 64'(j-3), 1'b1}) begin
                    errors++; $display("FAIL t4_beat%0d got v=%0b d=%h l=%0b exp v=1 d=%h l=1",
                                       j-3, tval, tdat, tlst, 64'hB2B0 + 64'(j-3));
                end
            end
            if (j >= 3) begin
                checks++;
                if ({pkts, cons} !== {16'(j + 1), 9'(256 + j)}) begin
                    errors++; $display("FAIL t4_count clk%0d got pkts=%0d cons=%0d exp %0d/%0d",
                                       j, pkts, cons, j + 1, 256 + j);
                end
            end
        end
        checks++;
        if (tval !== 1'b0) begin
            errors++; $display("FAIL t4_idle tval got %0b exp 0", tval);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midframe();
        for (int i = 0; i < 4; i++) mem[11+i] = mkw(64'hDEAD_0000 + 64'(i), 8'hFF, i == 3);
        trdy = 1'b0;
        prod = 9'd271;
        repeat (4) @(negedge clk);
        checks++;
        if (tval !== 1'b1) begin
            errors++; $display("FAIL t5_queued tval got %0b exp 1", tval);
        end
        rst  = 1'b1;
        prod = '0;
        @(negedge clk);
        checks++;
        if ({tval, rd_en, cons, pkts} !== {1'b0, 1'b0, 9'd0, 16'd0}) begin
            errors++; $display("FAIL t5_reset got tval=%0b rd_en=%0b cons=%0d pkts=%0d exp 0/0/0/0",
                               tval, rd_en, cons, pkts);
        end
        rst = 1'b0;
        mem[0] = mkw(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        mem[1] = mkw(64'hFEDC_BA98_7654_3210, 8'h7F, 1'b1);
        trdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (tval !== 1'b0) begin
                errors++; $display("FAIL t5_stale clk%0d tval got %0b exp 0", i, tval);
            end
        end
        prod = 9'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if ({tval, tdat, tkep, tlst} !== {1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0}) begin
                    errors++; $display("FAIL t5_beat0 got v=%0b d=%h k=%h l=%0b", tval, tdat, tkep, tlst);
                end
            end
            if (k == 4) begin
                checks++;
                if ({tval, tdat, tkep, tlst} !== {1'b1, 64'hFEDC_BA98_7654_3210, 8'h7F, 1'b1}) begin
                    errors++; $display("FAIL t5_beat1 got v=%0b d=%h k=%h l=%0b", tval, tdat, tkep, tlst);
                end
            end
            if (k == 5) begin
                checks++;
                if ({tval, cons, pkts} !== {1'b0, 9'd2, 16'd1}) begin
                    errors++; $display("FAIL t5_done got tval=%0b cons=%0d pkts=%0d exp 0/2/1", tval, cons, pkts);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scoreboard();
        localparam int NFR = 12;
        logic [DW-1:0] expq [$];
        int            lens [NFR];
        int            total = 0;
        int            got = 0;
        logic [15:0]   pk0;
        pk0 = pkts;
        lens[0] = 1;
        lens[1] = 190;
        for (int f = 2; f < NFR; f++) lens[f] = int'($urandom_range(1, 190));
        for (int f = 0; f < NFR; f++) total += lens[f];
        fork
            begin
                for (int f = 0; f < NFR; f++) begin
                    int            waitc;
                    int            used;
                    logic [63:0]   d;
                    logic [6:0]    kk;
                    logic          last;
                    logic [DW-1:0] w;
                    waitc = 0;
                    @(negedge clk);
                    used = ((int'(prod) + lens[f] - int'(cons)) % 512 + 512) % 512;
                    while (used > 2**AW && waitc < 5000) begin
                        @(negedge clk);
                        waitc++;
                        used = ((int'(prod) + lens[f] - int'(cons)) % 512 + 512) % 512;
                    end
                    if (waitc >= 5000) begin
                        checks++; errors++;
                        $display("FAIL t6_space frame%0d got no space exp space within 5000 clks", f);
                    end
                    for (int i = 0; i < lens[f]; i++) begin
                        d    = {$urandom, $urandom};
                        last = (i == lens[f] - 1);
                        kk   = last ? 7'($urandom) : 7'h7F;
                        w    = {d, kk, last};
                        mem[AW'(int'(prod) + i)] = w;
                        expq.push_back(w);
                    end
                    prod = prod + PW'(lens[f]);
                end
            end
            begin
                for (int c = 0; c < 20000 && got < total; c++) begin
                    logic [DW-1:0] ew;
                    @(negedge clk);
                    trdy = ($urandom_range(0, 99) >= 30);
                    checks++;
                    if (((int'(prod) - int'(cons)) % 512 + 512) % 512 > 2**AW) begin
                        errors++; $display("FAIL t6_order got cons=%0d prod=%0d exp cons<=prod", cons, prod);
                    end
                    if (tval && trdy) begin
                        checks++;
                        if (expq.size() == 0) begin
                            errors++; $display("FAIL t6_extra got beat d=%h exp none", tdat);
                        end else begin
                            ew = expq.pop_front();
                            if ({tdat, tkep, tlst} !== {ew[71:8], ew[7:1], 1'b1, ew[0]}) begin
                                errors++; $display("FAIL t6_beat%0d got d=%h k=%h l=%0b exp d=%h k=%h l=%0b",
                                                   got, tdat, tkep, tlst, ew[71:8], {ew[7:1], 1'b1}, ew[0]);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != total) begin
            errors++; $display("FAIL t6_beats got %0d exp %0d", got, total);
        end
        trdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cons, pkts} !== {prod, 16'(pk0 + 16'(NFR))}) begin
            errors++; $display("FAIL t6_final got cons=%0d pkts=%0d exp %0d/%0d", cons, pkts, prod, pk0 + 16'(NFR));
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_midframe();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
